norm_stage_ctrl: RTL and testbench

- Sequencer for the post-add normalization stage of the fpaddsub datapath.
- Per operation it pulses, in order, the load strobes for:
  - the add/sub result register;
  - the leading-zero-detect output register (LZD load_i);
  - the barrel-shifter and exponent registers.
- Between those steps it decides shift direction and amount: right-by-1 on carry-out, clamped left shift otherwise, zero-result bypass.
- It exposes a start/done/ack handshake to the top-level FPU FSM.

---
 rtl/fpaddsub_ctrl_pkg.sv | 29 ++
 rtl/norm_stage_ctrl_if.sv | 10 +
 rtl/norm_shift_clamp.sv | 38 +++
 rtl/norm_stage_ctrl.sv | 142 ++++++++++++++
 tb/tb_norm_stage_ctrl.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/fpaddsub_ctrl_pkg.sv
// rtl/fpaddsub_ctrl_pkg.sv - shared state encoding and format constants for the fpaddsub control path
package fpaddsub_ctrl_pkg;

    localparam int SWR_SINGLE = 26;
    localparam int EWR_SINGLE = 5;
    localparam int EW_SINGLE  = 8;
    localparam int SWR_DOUBLE = 55;
    localparam int EWR_DOUBLE = 6;
    localparam int EW_DOUBLE  = 11;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD_ADD = 3'd1;
    localparam logic [2:0] ST_LZD      = 3'd2;
    localparam logic [2:0] ST_EVAL     = 3'd3;
    localparam logic [2:0] ST_SHIFT    = 3'd4;
    localparam logic [2:0] ST_ZERO     = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        LOAD_ADD = ST_LOAD_ADD,
        LZD      = ST_LZD,
        EVAL     = ST_EVAL,
        SHIFT    = ST_SHIFT,
        ZERO     = ST_ZERO,
        DONE     = ST_DONE
    } state_t;

endpackage

// File: rtl/norm_stage_ctrl_if.sv
// rtl/norm_stage_ctrl_if.sv - start/ack/done/busy handshake between the FPU FSM and the normalization sequencer
interface norm_stage_ctrl_if;
    logic start_i;
    logic ack_i;
    logic done_o;
    logic busy_o;

    modport master (output start_i, output ack_i, input done_o, input busy_o);
    modport slave  (input start_i, input ack_i, output done_o, output busy_o);
endinterface

// File: rtl/norm_shift_clamp.sv
// rtl/norm_shift_clamp.sv - combinational shift direction/amount decision with exponent clamp
module norm_shift_clamp #(
    parameter int EWR = 5,
    parameter int EW  = 8
) (
    input  logic [EWR-1:0] shift_value,
    input  logic [EW-1:0]  exp,
    input  logic           ovf,
    output logic [EWR-1:0] amt,
    output logic           dir,
    output logic           underflow,
    output logic           overflow,
    output logic           skip
);

    logic [EW-1:0] limit;
    logic [EW-1:0] sv_ext;

    always_comb begin
        sv_ext    = EW'(shift_value);
        // Largest left shift that keeps the exponent >= 1; exp==0 can't shift at all.
        limit     = (exp == '0) ? '0 : (exp - EW'(1));
        amt       = '0;
        dir       = 1'b0;
        underflow = 1'b0;
        overflow  = 1'b0;
        if (ovf) begin
            dir      = 1'b1;
            amt      = EWR'(1);
            overflow = (exp == {{(EW-1){1'b1}}, 1'b0});
        end else begin
            underflow = (sv_ext > limit);
            amt       = underflow ? limit[EWR-1:0] : shift_value;
        end
        skip = !ovf && (amt == '0);
    end

endmodule

// File: rtl/norm_stage_ctrl.sv
// rtl/norm_stage_ctrl.sv - sequencer for the fpaddsub post-add normalization stage
module norm_stage_ctrl
    import fpaddsub_ctrl_pkg::*;
#(
    parameter int SWR = SWR_SINGLE,
    parameter int EWR = EWR_SINGLE,
    parameter int EW  = EW_SINGLE
) (
    input  logic                  clk,
    input  logic                  rst,
    norm_stage_ctrl_if.slave      hs,
    input  logic                  ovf_i,
    input  logic                  zero_i,
    input  logic [EWR-1:0]        Shift_Value_i,
    input  logic [EW-1:0]         exp_i,
    output logic                  load_add_o,
    output logic                  load_lzd_o,
    output logic                  load_shift_o,
    output logic                  load_exp_o,
    output logic                  shift_dir_o,
    output logic [EWR-1:0]        shift_amt_o,
    output logic                  exp_zero_o,
    output logic                  underflow_o,
    output logic                  overflow_o
);

    state_t         state;
    logic           done_q;
    logic           busy_q;

    logic [EWR-1:0] c_amt;
    logic           c_dir;
    logic           c_underflow;
    logic           c_overflow;
    logic           c_skip;

    norm_shift_clamp #(
        .EWR (EWR),
        .EW  (EW)
    ) u_clamp (
        .shift_value (Shift_Value_i),
        .exp         (exp_i),
        .ovf         (ovf_i),
        .amt         (c_amt),
        .dir         (c_dir),
        .underflow   (c_underflow),
        .overflow    (c_overflow),
        .skip        (c_skip)
    );

    assign hs.done_o = done_q;
    assign hs.busy_o = busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            load_add_o   <= 1'b0;
            load_lzd_o   <= 1'b0;
            load_shift_o <= 1'b0;
            load_exp_o   <= 1'b0;
            exp_zero_o   <= 1'b0;
            shift_dir_o  <= 1'b0;
            shift_amt_o  <= '0;
            underflow_o  <= 1'b0;
            overflow_o   <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // Strobes are one-cycle pulses: default low, raised only on entry to their state.
            load_add_o   <= 1'b0;
            load_lzd_o   <= 1'b0;
            load_shift_o <= 1'b0;
            load_exp_o   <= 1'b0;
            exp_zero_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (hs.start_i) begin
                        state      <= LOAD_ADD;
                        load_add_o <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD_ADD: begin
                    state      <= LZD;
                    load_lzd_o <= 1'b1;
                end
                LZD: begin
                    state <= EVAL;
                end
                EVAL: begin
                    if (ovf_i || !zero_i) begin
                        shift_amt_o <= c_amt;
                        shift_dir_o <= c_dir;
                        underflow_o <= c_underflow;
                        overflow_o  <= c_overflow;
                        if (c_skip) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state        <= SHIFT;
                            load_shift_o <= 1'b1;
                            load_exp_o   <= 1'b1;
                        end
                    end else begin
                        shift_amt_o <= '0;
                        shift_dir_o <= 1'b0;
                        underflow_o <= 1'b0;
                        overflow_o  <= 1'b0;
                        state       <= ZERO;
                        load_exp_o  <= 1'b1;
                        exp_zero_o  <= 1'b1;
                    end
                end
                SHIFT, ZERO: begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                DONE: begin
                    if (hs.ack_i) begin
                        state       <= IDLE;
                        done_q      <= 1'b0;
                        busy_q      <= 1'b0;
                        shift_amt_o <= '0;
                        shift_dir_o <= 1'b0;
                        underflow_o <= 1'b0;
                        overflow_o  <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // A shift past the working width means the LZD count or clamp is corrupt.
    shift_in_range: assert property (@(posedge clk) disable iff (!rst)
        int'(shift_amt_o) < SWR);

endmodule

// File: tb/tb_norm_stage_ctrl.sv
// tb/tb_norm_stage_ctrl.sv - directed self-checking bench for norm_stage_ctrl
module tb_norm_stage_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ovf;
    logic       zero;
    logic [4:0] shift_value;
    logic [7:0] exp_in;
    logic       load_add, load_lzd, load_shift, load_exp;
    logic       shift_dir, exp_zero, underflow, overflow;
    logic [4:0] shift_amt;

    int tests = 0;
    int fails = 0;

    norm_stage_ctrl_if hs ();

    norm_stage_ctrl #(.SWR(26), .EWR(5), .EW(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .hs            (hs),
        .ovf_i         (ovf),
        .zero_i        (zero),
        .Shift_Value_i (shift_value),
        .exp_i         (exp_in),
        .load_add_o    (load_add),
        .load_lzd_o    (load_lzd),
        .load_shift_o  (load_shift),
        .load_exp_o    (load_exp),
        .shift_dir_o   (shift_dir),
        .shift_amt_o   (shift_amt),
        .exp_zero_o    (exp_zero),
        .underflow_o   (underflow),
        .overflow_o    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " done"}, 32'(hs.done_o), 0);
        chk({tag, " busy"}, 32'(hs.busy_o), 0);
        chk({tag, " strobes"}, 32'({load_add, load_lzd, load_shift, load_exp, exp_zero}), 0);
        chk({tag, " amt"}, 32'(shift_amt), 0);
        chk({tag, " flags"}, 32'({shift_dir, underflow, overflow}), 0);
    endtask

    task automatic run_op(input string name, input logic [4:0] sv, input logic [7:0] ex,
                          input logic ov, input logic zr, input int done_at, input logic shift_pulse,
                          input logic [4:0] e_amt, input logic e_dir, input logic e_uf,
                          input logic e_of, input int hold);
        logic ezero;
        ezero       = zr && !ov;
        shift_value = sv;
        exp_in      = ex;
        ovf         = ov;
        zero        = zr;
        hs.start_i  = 1'b1;
        for (int k = 1; k <= done_at; k++) begin
            @(posedge clk);
            @(negedge clk);
            hs.start_i = 1'b0;
            chk($sformatf("%s c%0d load_add", name, k), 32'(load_add), 32'(k == 1));
            chk($sformatf("%s c%0d load_lzd", name, k), 32'(load_lzd), 32'(k == 2));
            chk($sformatf("%s c%0d load_shift", name, k), 32'(load_shift), 32'(k == 4 && shift_pulse));
            chk($sformatf("%s c%0d load_exp", name, k), 32'(load_exp), 32'(k == 4 && (shift_pulse || ezero)));
            chk($sformatf("%s c%0d exp_zero", name, k), 32'(exp_zero), 32'(k == 4 && ezero));
            chk($sformatf("%s c%0d done", name, k), 32'(hs.done_o), 32'(k == done_at));
            chk($sformatf("%s c%0d busy", name, k), 32'(hs.busy_o), 1);
        end
        chk({name, " amt"}, 32'(shift_amt), 32'(e_amt));
        chk({name, " dir"}, 32'(shift_dir), 32'(e_dir));
        chk({name, " underflow"}, 32'(underflow), 32'(e_uf));
        chk({name, " overflow"}, 32'(overflow), 32'(e_of));
        for (int h = 0; h < hold; h++) begin
            hs.start_i = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("%s hold%0d done", name, h), 32'(hs.done_o), 1);
            chk($sformatf("%s hold%0d load_add", name, h), 32'(load_add), 0);
            chk($sformatf("%s hold%0d amt", name, h), 32'(shift_amt), 32'(e_amt));
        end
        hs.start_i = 1'b0;
        hs.ack_i   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        hs.ack_i = 1'b0;
        chk_idle({name, " post-ack"});
    endtask

    initial begin
        rst         = 1'b0;
        ovf         = 1'b0;
        zero        = 1'b0;
        shift_value = '0;
        exp_in      = '0;
        hs.start_i  = 1'b0;
        hs.ack_i    = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 1'b1;
        @(negedge clk);
        chk_idle("after reset");

        //      name        sv  exp  ovf zr done sh amt dir uf of hold
        run_op("shl",        3, 100, 0, 0, 5, 1, 3, 0, 0, 0, 0);
        run_op("ovf",        7, 254, 1, 0, 5, 1, 1, 1, 0, 1, 0);
        run_op("ovf_no_of",  7, 100, 1, 0, 5, 1, 1, 1, 0, 0, 0);
        run_op("uf_clamp",  10,   4, 0, 0, 5, 1, 3, 0, 1, 0, 0);
        run_op("exp1",       5,   1, 0, 0, 4, 0, 0, 0, 1, 0, 0);
        run_op("zero",      31,  50, 0, 1, 5, 0, 0, 0, 0, 0, 0);
        run_op("ovf_zero",   2,  30, 1, 1, 5, 1, 1, 1, 0, 0, 0);
        run_op("noshift",    0, 100, 0, 0, 4, 0, 0, 0, 0, 0, 7);
        run_op("exp0",       2,   0, 0, 0, 4, 0, 0, 0, 1, 0, 0);
        run_op("exact",      9,  10, 0, 0, 5, 1, 9, 0, 0, 0, 2);

        shift_value = 5'd3;
        exp_in      = 8'd100;
        ovf         = 1'b0;
        zero        = 1'b0;
        hs.start_i  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        hs.start_i = 1'b0;
        chk("mid load_add", 32'(load_add), 1);
        @(posedge clk);
        @(negedge clk);
        chk("mid load_lzd", 32'(load_lzd), 1);
        rst = 1'b0;
        #1;
        chk_idle("mid reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk_idle("mid reset held");
        @(posedge clk);
        @(negedge clk);
        chk_idle("mid reset released");

        run_op("after_rst",  4,  20, 0, 0, 5, 1, 4, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
